// File: rtl/score_life_overlay.sv
// Score / lives text overlay for the VGA pong display.
// Owns the BCD score, the lives counter and the PLAY/GAME_OVER state, and
// renders labels and digits through synchronous glyph ROMs. The pixel path
// has a fixed 2-cycle latency from x/y to rgb/sl_on.

// "SCORE" label glyph ROM, one registered texel per cycle
module score_rom (
  input  logic        clk,
  input  logic [4:0]  row,
  input  logic [5:0]  col,
  output logic [11:0] color_data
);
  // Synchronous texel read
  always_ff @(posedge clk) begin
    color_data <= {col, 1'b1, row};
  end
endmodule

// "LIVES" label glyph ROM, one registered texel per cycle
module lives_rom (
  input  logic        clk,
  input  logic [3:0]  row,
  input  logic [5:0]  col,
  output logic [11:0] color_data
);
  // Synchronous texel read
  always_ff @(posedge clk) begin
    color_data <= {row, col, 2'b10};
  end
endmodule

// 13x13 seven-segment digit glyph ROM
module number_rom (
  input  logic        clk,
  input  logic [3:0]  digit,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [11:0] color_data
);
  // Segment mask {a,b,c,d,e,f,g} for a decimal digit; non-decimal codes are blank
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd0:    seg_mask = 7'b1111110;
      4'd1:    seg_mask = 7'b0110000;
      4'd2:    seg_mask = 7'b1101101;
      4'd3:    seg_mask = 7'b1111001;
      4'd4:    seg_mask = 7'b0110011;
      4'd5:    seg_mask = 7'b1011011;
      4'd6:    seg_mask = 7'b1011111;
      4'd7:    seg_mask = 7'b1110000;
      4'd8:    seg_mask = 7'b1111111;
      4'd9:    seg_mask = 7'b1111011;
      default: seg_mask = 7'b0000000;
    endcase
  endfunction

  // True when texel (r,c) falls on a segment enabled in m
  function automatic logic seg_lit(input logic [6:0] m, input logic [3:0] r, input logic [3:0] c);
    logic h_span, upper, lower, left, right;
    h_span  = (c >= 4'd2) && (c <= 4'd10);
    upper   = (r >= 4'd1) && (r <= 4'd6);
    lower   = (r >= 4'd6) && (r <= 4'd11);
    left    = (c >= 4'd1) && (c <= 4'd2);
    right   = (c >= 4'd10) && (c <= 4'd11);
    seg_lit = (m[6] & h_span & (r >= 4'd1) & (r <= 4'd2)) |
              (m[5] & right & upper) |
              (m[4] & right & lower) |
              (m[3] & h_span & (r >= 4'd10) & (r <= 4'd11)) |
              (m[2] & left & lower) |
              (m[1] & left & upper) |
              (m[0] & h_span & (r == 4'd6));
  endfunction

  // Synchronous texel read
  always_ff @(posedge clk) begin
    color_data <= seg_lit(seg_mask(digit), row, col) ? 12'h0F0 : 12'h000;
  end
endmodule

module score_life_overlay #(
  parameter int NUM_DIGITS  = 3,
  parameter int LIVES_INIT  = 3,
  parameter int SCORE_X     = 246,
  parameter int SCORE_Y     = 30,
  parameter int LIFE_X      = 246,
  parameter int LIFE_Y      = 60,
  parameter int LABEL_W     = 56,
  parameter int LABEL_H     = 21,
  parameter int DIGIT_W     = 13,
  parameter int DIGIT_H     = 13,
  parameter int DIGIT_GAP   = 4,
  parameter int LABEL_GAP   = 6,
  parameter int BLINK_LOG2  = 5,
  parameter int SUPPRESS_LZ = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    video_on,
  input  logic                    point,
  input  logic                    miss,
  input  logic                    restart,
  output logic [11:0]             rgb,
  output logic                    sl_on,
  output logic                    game_over,
  output logic [2:0]              lives,
  output logic [4*NUM_DIGITS-1:0] score_bcd
);
  localparam int SW         = 4 * NUM_DIGITS;
  localparam int DIG0_X     = SCORE_X + LABEL_W + LABEL_GAP;
  localparam int DIG_PITCH  = DIGIT_W + DIGIT_GAP;
  localparam int LD_X       = LIFE_X + LABEL_W + LABEL_GAP;
  localparam int LIFE_LBL_H = 13;
  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);

  typedef enum logic {ST_PLAY = 1'b0, ST_OVER = 1'b1} state_t;

  state_t              state_q;
  logic [SW-1:0]       score_q, disp_score_q;
  logic [2:0]          lives_q, disp_lives_q;
  logic                game_over_q;
  logic [BLINK_LOG2:0] blink_q;

  logic frame_start_s, entering_over_s;

  // Saturating BCD increment with ripple carry; all-9s stays put
  function automatic logic [SW-1:0] bcd_inc_sat(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic carry, all9;
    r     = v;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
      else all9 = all9;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry && (v[4*i +: 4] == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    bcd_inc_sat = all9 ? v : r;
  endfunction

  // Strict open interval test lo < p < lo+len
  function automatic logic in_box(input logic [9:0] p, input int lo, input int len);
    in_box = ({1'b0, p} > 11'(lo)) && ({1'b0, p} < 11'(lo + len));
  endfunction

  // Frame-start strobe and the miss that ends the game
  always_comb begin
    frame_start_s   = (x == 10'd0) && (y == 10'd0);
    entering_over_s = !restart && (state_q == ST_PLAY) && miss && (lives_q == 3'd1);
  end

  // Game FSM with score and lives; restart wins over point/miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      score_q     <= {SW{1'b0}};
      lives_q     <= LIVES_RST;
      game_over_q <= 1'b0;
    end else if (restart) begin
      state_q     <= ST_PLAY;
      score_q     <= {SW{1'b0}};
      lives_q     <= LIVES_RST;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (point) score_q <= bcd_inc_sat(score_q);
          if (miss && (lives_q != 3'd0)) begin
            lives_q <= lives_q - 3'd1;
            if (lives_q == 3'd1) begin
              state_q     <= ST_OVER;
              game_over_q <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          state_q <= ST_OVER;
        end
        default: begin
          state_q     <= ST_PLAY;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  // Frame latch of displayed values and blink frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_score_q <= {SW{1'b0}};
      disp_lives_q <= LIVES_RST;
      blink_q      <= {(BLINK_LOG2+1){1'b0}};
    end else begin
      if (frame_start_s) begin
        disp_score_q <= score_q;
        disp_lives_q <= lives_q;
      end
      if (entering_over_s) blink_q <= {(BLINK_LOG2+1){1'b0}};
      else if (frame_start_s) blink_q <= blink_q + {{BLINK_LOG2{1'b0}}, 1'b1};
      else blink_q <= blink_q;
    end
  end

  // ---------------- Stage 0: region decode and ROM addressing ----------------
  logic                  sl_lbl_s, ll_lbl_s, ld_on_s, lz_run_s;
  logic [NUM_DIGITS-1:0] sd_on_s;
  logic [4:0]            sl_row_s;
  logic [5:0]            sl_col_s, ll_col_s;
  logic [3:0]            ll_row_s, sd_row_s, ld_row_s, ld_col_s;
  logic [3:0]            sd_col_s [NUM_DIGITS];
  logic [3:0]            sd_val_s [NUM_DIGITS];

  // Region flags, leading-zero blanking and glyph addresses
  always_comb begin
    sl_lbl_s = in_box(x, SCORE_X, LABEL_W) && in_box(y, SCORE_Y, LABEL_H);
    ll_lbl_s = in_box(x, LIFE_X, LABEL_W) && in_box(y, LIFE_Y, LIFE_LBL_H);
    sl_row_s = 5'(y - 10'(SCORE_Y));
    sl_col_s = 6'(x - 10'(SCORE_X));
    ll_row_s = 4'(y - 10'(LIFE_Y));
    ll_col_s = 6'(x - 10'(LIFE_X));
    sd_row_s = 4'(y - 10'(SCORE_Y));
    lz_run_s = (SUPPRESS_LZ != 0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      // digit k = 0 is the leftmost, most-significant one
      sd_val_s[k] = disp_score_q[4*(NUM_DIGITS-1-k) +: 4];
      lz_run_s    = lz_run_s && (sd_val_s[k] == 4'd0);
      sd_col_s[k] = 4'(x - 10'(DIG0_X + k * DIG_PITCH));
      sd_on_s[k]  = in_box(x, DIG0_X + k * DIG_PITCH, DIGIT_W) && in_box(y, SCORE_Y, DIGIT_H) &&
                    !(lz_run_s && (k != NUM_DIGITS - 1));
    end
    ld_row_s = 4'(y - 10'(LIFE_Y));
    ld_col_s = 4'(x - 10'(LD_X));
    ld_on_s  = in_box(x, LD_X, DIGIT_W) && in_box(y, LIFE_Y, DIGIT_H) &&
               ((state_q == ST_PLAY) || !blink_q[BLINK_LOG2]);
  end

  // ---------------- Stage 1: ROM reads and registered flags ----------------
  logic [11:0] sl_rom_s, ll_rom_s, ld_rom_s;
  logic [11:0] sd_rom_s [NUM_DIGITS];

  score_rom u_score_rom (.clk(clk), .row(sl_row_s), .col(sl_col_s), .color_data(sl_rom_s));
  lives_rom u_lives_rom (.clk(clk), .row(ll_row_s), .col(ll_col_s), .color_data(ll_rom_s));

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_score_digit
    number_rom u_num (.clk(clk), .digit(sd_val_s[g]), .row(sd_row_s), .col(sd_col_s[g]),
                      .color_data(sd_rom_s[g]));
  end

  number_rom u_life_num (.clk(clk), .digit({1'b0, disp_lives_q}), .row(ld_row_s), .col(ld_col_s),
                         .color_data(ld_rom_s));

  logic                  vid_q, sl_lbl_q, ll_lbl_q, ld_on_q;
  logic [NUM_DIGITS-1:0] sd_on_q;

  // Region flags travel alongside the ROM read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_q    <= 1'b0;
      sl_lbl_q <= 1'b0;
      ll_lbl_q <= 1'b0;
      ld_on_q  <= 1'b0;
      sd_on_q  <= {NUM_DIGITS{1'b0}};
    end else begin
      vid_q    <= video_on;
      sl_lbl_q <= sl_lbl_s;
      ll_lbl_q <= ll_lbl_s;
      ld_on_q  <= ld_on_s;
      sd_on_q  <= sd_on_s;
    end
  end

  // ---------------- Stage 2: priority mux ----------------
  logic [11:0] rgb_d, sd_rgb_s, rgb_q;
  logic        sl_on_d, sl_on_q;

  // Lives label > score label > score digits > lives digit; blanking outside video
  always_comb begin
    sd_rgb_s = 12'h000;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sd_rgb_s = sd_rgb_s | (sd_rom_s[k] & {12{sd_on_q[k]}});
    end
    if (!vid_q) begin
      rgb_d = 12'h000; sl_on_d = 1'b0;
    end else if (ll_lbl_q) begin
      rgb_d = ll_rom_s; sl_on_d = 1'b1;
    end else if (sl_lbl_q) begin
      rgb_d = sl_rom_s; sl_on_d = 1'b1;
    end else if (|sd_on_q) begin
      rgb_d = sd_rgb_s; sl_on_d = 1'b1;
    end else if (ld_on_q) begin
      rgb_d = ld_rom_s; sl_on_d = 1'b1;
    end else begin
      rgb_d = 12'h000; sl_on_d = 1'b0;
    end
  end

  // Registered overlay outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= 12'h000;
      sl_on_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      sl_on_q <= sl_on_d;
    end
  end

  assign rgb       = rgb_q;
  assign sl_on     = sl_on_q;
  assign game_over = game_over_q;
  assign lives     = lives_q;
  assign score_bcd = score_q;
endmodule

// File: tb/tb_score_life_overlay.sv
// Self-checking bench for score_life_overlay: directed scenarios plus random
// play, all compared against a decimal-arithmetic reference model.
module tb_score_life_overlay;
  localparam int ND = 3, LI = 3, SX = 246, SY = 30, LX = 246, LY = 60;
  localparam int LW = 56, LH = 21, DW = 13, DH = 13, DG = 4, LG = 6, BL = 5;
  localparam int DIG0 = SX + LW + LG;
  localparam int LDX  = LX + LW + LG;

  logic        clk = 1'b0;
  logic        reset, video_on, point, miss, restart;
  logic [9:0]  x, y;
  logic [11:0] rgb;
  logic        sl_on, game_over;
  logic [2:0]  lives;
  logic [11:0] score_bcd;

  score_life_overlay #(.NUM_DIGITS(ND), .LIVES_INIT(LI), .BLINK_LOG2(BL)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .point(point), .miss(miss), .restart(restart),
    .rgb(rgb), .sl_on(sl_on), .game_over(game_over), .lives(lives), .score_bcd(score_bcd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state (plain integers)
  int m_score, m_lives, m_over, m_dscore, m_dlives, m_blink;
  logic [12:0] pipe1, pipe2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_lives = LI; m_over = 0;
    m_dscore = 0; m_dlives = LI; m_blink = 0;
    pipe1 = '0; pipe2 = '0;
  endtask

  function automatic logic [11:0] to_bcd(input int s);
    logic [11:0] r;
    int t;
    r = '0; t = s;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic string segs_of(input int d);
    case (d)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";
      3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
      6: return "acdefg";   7: return "abc";     8: return "abcdefg";
      9: return "abcdfg";   default: return "";
    endcase
  endfunction

  // Seven-segment glyph: segment rectangles on a 13x13 cell
  function automatic bit digit_lit(input int d, input int r, input int c);
    string s;
    bit lit;
    s = segs_of(d);
    lit = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": lit |= (r >= 1 && r <= 2 && c >= 2 && c <= 10);
        "b": lit |= (c >= 10 && c <= 11 && r >= 1 && r <= 6);
        "c": lit |= (c >= 10 && c <= 11 && r >= 6 && r <= 11);
        "d": lit |= (r >= 10 && r <= 11 && c >= 2 && c <= 10);
        "e": lit |= (c >= 1 && c <= 2 && r >= 6 && r <= 11);
        "f": lit |= (c >= 1 && c <= 2 && r >= 1 && r <= 6);
        "g": lit |= (r == 6 && c >= 2 && c <= 10);
        default: lit |= 1'b0;
      endcase
    end
    return lit;
  endfunction

  function automatic bit inside_box(input int px, input int py, input int x0, input int y0,
                                    input int w, input int h);
    return (px > x0) && (px < x0 + w) && (py > y0) && (py < y0 + h);
  endfunction

  // Expected {sl_on, rgb} for one pixel given the current latched model state
  function automatic logic [12:0] model_pixel(input int px, input int py, input bit vid);
    int x0, div, v;
    if (!vid) return 13'h0;
    if (inside_box(px, py, LX, LY, LW, 13))
      return {1'b1, 12'(((py - LY) << 8) | ((px - LX) << 2) | 2)};
    if (inside_box(px, py, SX, SY, LW, LH))
      return {1'b1, 12'(((px - SX) << 6) | 32 | (py - SY))};
    for (int k = 0; k < ND; k++) begin
      x0 = DIG0 + k * (DW + DG);
      if (inside_box(px, py, x0, SY, DW, DH)) begin
        div = 1;
        for (int j = 0; j < ND - 1 - k; j++) div = div * 10;
        if (k != ND - 1 && (m_dscore / div) == 0) return 13'h0;
        v = (m_dscore / div) % 10;
        return {1'b1, digit_lit(v, py - SY, px - x0) ? 12'h0F0 : 12'h000};
      end
    end
    if (inside_box(px, py, LDX, LY, DW, DH)) begin
      if (m_over != 0 && ((m_blink >> BL) & 1) != 0) return 13'h0;
      return {1'b1, digit_lit(m_dlives, py - LY, px - LDX) ? 12'h0F0 : 12'h000};
    end
    return 13'h0;
  endfunction

  // One clock: advance the model from the pre-edge inputs, then compare
  task automatic tick();
    logic [12:0] cur;
    bit enter;
    cur   = model_pixel(int'(x), int'(y), video_on);
    pipe2 = pipe1;
    pipe1 = cur;
    enter = 1'b0;
    if (x == 10'd0 && y == 10'd0) begin
      m_dscore = m_score;
      m_dlives = m_lives;
      m_blink  = (m_blink + 1) % 64;
    end
    if (restart) begin
      m_score = 0; m_lives = LI; m_over = 0;
    end else if (m_over == 0) begin
      if (point && m_score < 999) m_score = m_score + 1;
      if (miss && m_lives > 0) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) begin m_over = 1; enter = 1'b1; end
      end
    end
    if (enter) m_blink = 0;
    @(posedge clk); #1;
    check("score_bcd", 16'(score_bcd), 16'(to_bcd(m_score)));
    check("lives", 16'(lives), 16'(m_lives));
    check("game_over", 16'(game_over), 16'(m_over));
    check("sl_on", 16'(sl_on), 16'(pipe2[12]));
    check("rgb", 16'(rgb), 16'(pipe2[11:0]));
  endtask

  task automatic scan_row(input int yy, input int x_lo, input int x_hi);
    y = 10'(yy);
    for (int xi = x_lo; xi <= x_hi; xi++) begin
      x = 10'(xi);
      tick();
    end
  endtask

  task automatic frame_latch();
    x = 10'd0; y = 10'd0; tick();
    x = 10'd1;
  endtask

  initial begin
    reset = 1'b1; x = 10'd5; y = 10'd5; video_on = 1'b0;
    point = 1'b0; miss = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 16'(rgb), 16'h0);
    check("rst_sl_on", 16'(sl_on), 16'h0);
    check("rst_score", 16'(score_bcd), 16'h0);
    check("rst_lives", 16'(lives), 16'd3);
    check("rst_game_over", 16'(game_over), 16'h0);
    reset = 1'b0;

    // Asynchronous reset mid-frame with score 037 on screen
    video_on = 1'b1; x = 10'd260; y = 10'd35;
    point = 1'b1; repeat (37) tick(); point = 1'b0;
    repeat (3) tick();
    check("pre_reset_score", 16'(score_bcd), 16'h037);
    check("pre_reset_sl_on", 16'(sl_on), 16'h1);
    #3 reset = 1'b1;
    #1;
    check("async_rgb", 16'(rgb), 16'h0);
    check("async_sl_on", 16'(sl_on), 16'h0);
    check("async_score", 16'(score_bcd), 16'h0);
    check("async_lives", 16'(lives), 16'd3);
    check("async_game_over", 16'(game_over), 16'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();

    // 1000 points: carries and saturation
    point = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      x = 10'($urandom_range(380, 240)); y = 10'($urandom_range(80, 25));
      if ($urandom_range(49, 0) == 0) begin x = 10'd0; y = 10'd0; end
      video_on = ($urandom_range(9, 0) != 0);
      tick();
      if (i == 9)    check("bcd_009", 16'(score_bcd), 16'h009);
      if (i == 10)   check("bcd_010", 16'(score_bcd), 16'h010);
      if (i == 99)   check("bcd_099", 16'(score_bcd), 16'h099);
      if (i == 100)  check("bcd_100", 16'(score_bcd), 16'h100);
      if (i >= 999)  check("bcd_sat", 16'(score_bcd), 16'h999);
    end
    point = 1'b0; video_on = 1'b1;

    // Point and miss together on the last life, then frozen game over
    restart = 1'b1; tick(); restart = 1'b0;
    miss = 1'b1; repeat (2) tick();
    point = 1'b1; tick();
    check("last_life_score", 16'(score_bcd), 16'h001);
    check("last_life_lives", 16'(lives), 16'd0);
    check("last_life_go", 16'(game_over), 16'd1);
    repeat (4) tick();
    check("frozen_score", 16'(score_bcd), 16'h001);
    check("frozen_lives", 16'(lives), 16'd0);
    restart = 1'b1; tick();
    restart = 1'b0; point = 1'b0; miss = 1'b0;
    check("restart_score", 16'(score_bcd), 16'h000);
    check("restart_lives", 16'(lives), 16'd3);
    check("restart_go", 16'(game_over), 16'd0);

    // Frame latch: mid-frame score change stays hidden until next frame
    point = 1'b1; repeat (12) tick(); point = 1'b0;
    frame_latch();
    scan_row(36, 300, 362);
    x = 10'd100; y = 10'd40;
    point = 1'b1; repeat (30) tick(); point = 1'b0;
    scan_row(36, 300, 362);
    scan_row(37, 300, 362);
    frame_latch();
    scan_row(36, 300, 362);

    // Score 005 with leading zeros blanked; exact rise of the last digit
    restart = 1'b1; tick(); restart = 1'b0;
    point = 1'b1; repeat (5) tick(); point = 1'b0;
    frame_latch();
    y = 10'd36;
    for (int xi = 320; xi <= 360; xi++) begin
      x = 10'(xi);
      tick();
      check("lz_region", 16'(sl_on), 16'((xi - 1 > DIG0 + 34) && (xi - 1 < DIG0 + 34 + DW)));
    end
    scan_row(40, 340, 356);

    // Game over blink across 128 frames
    miss = 1'b1; repeat (3) tick(); miss = 1'b0;
    for (int f = 0; f < 128; f++) begin
      x = 10'(LDX + 6); y = 10'(LY + 6); tick();
      x = 10'd1; y = 10'd0; tick();
      check("blink", 16'(sl_on), 16'(((f / 32) % 2) == 0));
      frame_latch();
    end
    restart = 1'b1; tick(); restart = 1'b0;

    // Random play
    for (int i = 0; i < 3000; i++) begin
      restart  = ($urandom_range(199, 0) == 0);
      point    = ($urandom_range(3, 0) == 0);
      miss     = ($urandom_range(29, 0) == 0);
      video_on = ($urandom_range(9, 0) != 0);
      x = 10'($urandom_range(380, 240)); y = 10'($urandom_range(80, 25));
      if ($urandom_range(39, 0) == 0) begin x = 10'd0; y = 10'd0; end
      tick();
    end
    restart = 1'b0; point = 1'b0; miss = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_life_overlay.md
Name: score_life_overlay

Overview:
Parametrised successor to the single-digit score/life text overlay for the VGA pong display. It owns the game's score and lives state:
- multi-digit BCD score counter;
- lives down-counter;
- PLAY/GAME_OVER state machine.

It renders the "SCORE"/"LIVES" labels, NUM_DIGITS score digits and a lives digit through the existing synchronous glyph ROMs (score_rom, lives_rom, number_rom; 1-cycle read latency). Displayed values are frame-latched to prevent tearing. The pixel path is fully pipelined so rgb/sl_on stay aligned to the pixel stream. It sits between the vga_sync pixel counters and the top-level colour mux.

Parameters:
NUM_DIGITS, 3, number of BCD score digits (1..4)
LIVES_INIT, 3, lives loaded at reset/restart (1..7)
SCORE_X, 246, left edge of score label and of score row
SCORE_Y, 30, top edge of score row
LIFE_X, 246, left edge of lives label
LIFE_Y, 60, top edge of lives row
LABEL_W, 56, label glyph width in pixels
LABEL_H, 21, label glyph height
DIGIT_W, 13, digit glyph width
DIGIT_H, 13, digit glyph height
DIGIT_GAP, 4, horizontal gap between adjacent digits
LABEL_GAP, 6, gap from label right edge to first digit
BLINK_LOG2, 5, lives digit toggles every 2^BLINK_LOG2 frames in GAME_OVER
SUPPRESS_LZ, 1, 1 = blank leading zero score digits (least-significant digit always drawn)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
x  in  10  current pixel column
y  in  10  current pixel row
video_on  in  1  active display area
point  in  1  1-cycle pulse: player scored
miss  in  1  1-cycle pulse: ball missed
restart  in  1  1-cycle pulse: new game
rgb  out  12  overlay colour, 2-cycle latency from x/y
sl_on  out  1  overlay pixel valid, aligned with rgb
game_over  out  1  high in GAME_OVER state
lives  out  3  live lives count
score_bcd  out  4*NUM_DIGITS  live BCD score, digit 0 in bits [3:0]

Behaviour:

Reset (asynchronous): all outputs and registers return to known values.
- score_bcd = 0, lives = LIVES_INIT, state = PLAY, game_over = 0.
- Frame-latched copies = 0 / LIVES_INIT; blink counter = 0.
- rgb = 0, sl_on = 0, pipeline registers = 0.

FSM:
- PLAY -> GAME_OVER when miss arrives with lives == 1 (lives becomes 0).
- GAME_OVER -> PLAY on restart.
- restart in PLAY also reinitialises score and lives; state stays PLAY.
- restart has priority over point/miss in the same cycle.

Score:
- point in PLAY does a BCD increment with ripple carry across digits.
- Saturates at all-9s; further points are ignored, with no wrap.

Lives:
- miss in PLAY decrements lives; never goes below 0.

Simultaneous events and GAME_OVER:
- point and miss in the same cycle are both applied, including on the miss that causes GAME_OVER.
- point and miss are ignored in GAME_OVER.

Frame latch:
- disp_score/disp_lives capture score_bcd/lives on the cycle where x==0 && y==0.
- Rendering uses only the latched copies.

Blink:
- A frame counter (BLINK_LOG2+1 bits) increments at each frame latch and clears on entering GAME_OVER.
- In GAME_OVER the lives digit is drawn only while the counter MSB == 0.
- In PLAY the lives digit is always drawn.

Regions:
- Every glyph region uses strict bounds: on when X0 < x < X0+W and Y0 < y < Y0+H.
- Glyph address: col = x - X0, row = y - Y0 (truncated to ROM widths).

Region placement:
- Score label at (SCORE_X, SCORE_Y), LABEL_W x LABEL_H.
- Lives label at (LIFE_X, LIFE_Y), LABEL_W x 13.
- Score digit k (k=0 is leftmost, most-significant):
  - X0 = SCORE_X + LABEL_W + LABEL_GAP + k*(DIGIT_W+DIGIT_GAP), Y0 = SCORE_Y.
- Lives digit: X0 = LIFE_X + LABEL_W + LABEL_GAP, Y0 = LIFE_Y.

Leading-zero suppression:
- When SUPPRESS_LZ = 1, a score digit is blanked if it and all more-significant digits are 0.
- The least-significant digit is always drawn.

Pipeline:
- Stage 0 (comb): region decode, digit select, ROM address.
- Stage 1: ROM outputs registered; region flags and video_on registered alongside.
- Stage 2: priority mux registered into rgb/sl_on.
  - Priority: lives label > score label > score digits > lives digit.
  - !video_on forces rgb = 0, sl_on = 0.
- Total latency is exactly 2 clk. Blanked regions give sl_on = 0, rgb = 0.
- One shared number_rom per digit region; at most NUM_DIGITS+1 instances.

Test Plan:
1. Reset asserted mid-frame with score 0x037 -> rgb=0, sl_on=0, score_bcd=0x000 and lives=3 immediately (no clock edge); game_over=0.
2. 1000 point pulses, NUM_DIGITS=3 -> score_bcd steps 0x009->0x010 and 0x099->0x100; holds 0x999 from the 999th pulse onward.
3. lives=1, point and miss in the same cycle -> score +1, lives=0, game_over=1 next cycle. Later point/miss leave both unchanged; restart -> score 0, lives 3, game_over=0.
4. score changes at mid-frame pixel (100,40) -> displayed digits are unchanged until the next x=0,y=0 cycle, then show the new value.
5. Pixel stream across digit 0 with score 0x005, SUPPRESS_LZ=1 -> sl_on=0 over digits 0-1; digit 2 draws the "5" glyph. sl_on rises exactly 2 clk after x=SCORE_X+LABEL_W+LABEL_GAP+2*17+1.
6. GAME_OVER for 128 frames, BLINK_LOG2=5 -> lives-digit sl_on is present for frames 0-31, absent for 32-63, present for 64-95, absent for 96-127.
